bit_ser_addsub: RTL and testbench



---
 rtl/bit_ser_pkg.sv | 13 +
 rtl/bit_ser_fa.sv | 32 +++
 rtl/bit_ser_addsub.sv | 106 ++++++++++
 tb/tb_bit_ser_addsub.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/bit_ser_pkg.sv
// Shared encodings for the bit-serial adder/subtractor.
package bit_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/bit_ser_fa.sv
// One-bit full adder with a registered carry; the carry presets to the mode bit
// so that subtraction gets its +1 for free.
module bit_ser_fa (
  input  logic clk,
  input  logic clr_n,
  input  logic load,
  input  logic mode,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry_next,
  output logic carry_in
);

  logic carry_q;

  assign sum        = a ^ b ^ carry_q;
  assign carry_next = (a & b) | (a & carry_q) | (b & carry_q);
  assign carry_in   = carry_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      carry_q <= 1'b0;
    end else if (load) begin
      carry_q <= mode;
    end else if (en) begin
      carry_q <= carry_next;
    end
  end

endmodule

// File: rtl/bit_ser_addsub.sv
// Bit-serial adder/subtractor: LSB-first, one bit per clock, parallel result
// with carry/overflow flags and a busy/done handshake.
module bit_ser_addsub
  import bit_ser_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             serial_result,
  output logic             carry_out,
  output logic             overflow
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             mode;

  logic fa_load;
  logic fa_en;
  logic sum_bit;
  logic carry_next;
  logic carry_msb_in;
  logic last_bit;

  assign fa_load  = (state == ST_IDLE) && start;
  assign fa_en    = (state == ST_SHIFT);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // The mode bit for the preset comes straight from sub, since mode is loaded on the same edge.
  bit_ser_fa u_fa (
    .clk        (clk),
    .clr_n      (clr_n),
    .load       (fa_load),
    .mode       (sub),
    .en         (fa_en),
    .a          (a_sh[0]),
    .b          (b_sh[0] ^ mode),
    .sum        (sum_bit),
    .carry_next (carry_next),
    .carry_in   (carry_msb_in)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      a_sh          <= '0;
      b_sh          <= '0;
      mode          <= MODE_ADD;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      serial_result <= 1'b0;
      carry_out     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh      <= a_in;
            b_sh      <= b_in;
            mode      <= sub;
            cnt       <= '0;
            busy      <= 1'b1;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sh          <= a_sh >> 1;
          b_sh          <= b_sh >> 1;
          result        <= {sum_bit, result[WIDTH-1:1]};
          serial_result <= sum_bit;
          cnt           <= cnt + 1'b1;
          // On the MSB the registered carry is the carry into the sign bit.
          if (last_bit) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            carry_out <= carry_next;
            overflow  <= carry_msb_in ^ carry_next;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          done          <= 1'b0;
          serial_result <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_ser_addsub.sv
// Testbench for bit_ser_addsub: 8- and 16-bit instances checked against an
// arithmetic reference model with directed and random operands.
module tb_bit_ser_addsub;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start8;
  logic        start16;
  logic        sub_bus;
  logic [15:0] a_bus;
  logic [15:0] b_bus;

  logic        busy8, done8, ser8, cout8, ovf8;
  logic [7:0]  res8;
  logic        busy16, done16, ser16, cout16, ovf16;
  logic [15:0] res16;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bit_ser_addsub #(.WIDTH(8)) u8 (
    .clk(clk), .clr_n(clr_n), .start(start8), .sub(sub_bus),
    .a_in(a_bus[7:0]), .b_in(b_bus[7:0]), .busy(busy8), .done(done8),
    .result(res8), .serial_result(ser8), .carry_out(cout8), .overflow(ovf8)
  );

  bit_ser_addsub #(.WIDTH(16)) u16 (
    .clk(clk), .clr_n(clr_n), .start(start16), .sub(sub_bus),
    .a_in(a_bus), .b_in(b_bus), .busy(busy16), .done(done16),
    .result(res16), .serial_result(ser16), .carry_out(cout16), .overflow(ovf16)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain modular arithmetic with two's-complement sign rules.
  task automatic refModel(input int w, input logic [15:0] a, input logic [15:0] b, input logic s,
                          output logic [31:0] r, output logic c, output logic v);
    longint unsigned mask, bb, full;
    logic sa, sb, sr;
    mask = (64'd1 << w) - 1;
    bb   = s ? (~longint'(b) & mask) : (longint'(b) & mask);
    full = (longint'(a) & mask) + bb + longint'(s);
    r    = 32'(full & mask);
    c    = full[w];
    sa   = a[w-1];
    sb   = bb[w-1];
    sr   = r[w-1];
    v    = (sa == sb) && (sr != sa);
  endtask

  task automatic setStart(input int w, input logic v);
    if (w == 8) start8 = v;
    else        start16 = v;
  endtask

  function automatic logic [2:0] hsOf(input int w);
    return (w == 8) ? {busy8, done8, ser8} : {busy16, done16, ser16};
  endfunction

  function automatic logic [17:0] resOf(input int w);
    return (w == 8) ? {cout8, ovf8, 8'h00, res8} : {cout16, ovf16, res16};
  endfunction

  // glitch: 0 = none, else the cycle after which a stray start is raised.
  task automatic applyStimulus(input int w, input logic [15:0] a, input logic [15:0] b,
                               input logic s, input int glitch);
    logic [31:0] er;
    logic        ec, ev;
    logic [2:0]  hs;
    refModel(w, a, b, s, er, ec, ev);
    a_bus = a; b_bus = b; sub_bus = s;
    setStart(w, 1'b1);
    @(posedge clk); #1;
    setStart(w, 1'b0);
    a_bus = 16'($urandom); b_bus = 16'($urandom); sub_bus = 1'($urandom);
    hs = hsOf(w);
    checkOutput("busy_t0", 32'(hs[2:1]), 32'b10);
    for (int i = 1; i <= w; i++) begin
      @(posedge clk); #1;
      if (glitch != 0 && i == glitch + 1) setStart(w, 1'b0);
      hs = hsOf(w);
      checkOutput("serial_bit", 32'(hs[0]), 32'(er[i-1]));
      checkOutput("busy_done", 32'(hs[2:1]), (i < w) ? 32'b10 : 32'b01);
      if (i == glitch) begin
        setStart(w, 1'b1);
        a_bus = 16'h0064; b_bus = 16'h0064; sub_bus = 1'b1;
      end
    end
    checkOutput("result", 32'(resOf(w)), {14'd0, ec, ev, er[15:0]});
    @(posedge clk); #1;
    if (glitch == w) setStart(w, 1'b0);
    checkOutput("after_done", 32'(hsOf(w)), 32'b000);
    checkOutput("result_hold", 32'(resOf(w)), {14'd0, ec, ev, er[15:0]});
    if (glitch == w) begin
      @(posedge clk); #1;
      checkOutput("done_start_dropped", 32'(hsOf(w)), 32'b000);
    end
  endtask

  initial begin
    logic [29:0] obs_v, exp_v;
    clr_n = 1'b0; start8 = 1'b0; start16 = 1'b0;
    sub_bus = 1'b0; a_bus = '0; b_bus = '0;
    #12;
    checkOutput("reset8", {busy8, done8, ser8, cout8, ovf8, res8}, 32'd0);
    checkOutput("reset16", {busy16, done16, ser16, cout16, ovf16, res16}, 32'd0);
    #3 clr_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed 8-bit operations");
    applyStimulus(8, 16'd7, 16'd3, 1'b0, 0);
    applyStimulus(8, 16'd6, 16'd4, 1'b1, 0);
    applyStimulus(8, 16'd127, 16'd1, 1'b0, 0);
    applyStimulus(8, 16'd255, 16'd1, 1'b0, 0);
    applyStimulus(8, 16'd3, 16'd5, 1'b1, 0);
    checkOutput("const_7p3", 32'(res8), 32'd2 + 32'hFC);

    $display("[TB] handshake: start held high");
    a_bus = 16'd1; b_bus = 16'd2; sub_bus = 1'b0; start8 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      obs_v[c] = done8;
      exp_v[c] = ((c % 10) == 8);
    end
    start8 = 1'b0;
    checkOutput("held_done_pattern", 32'(obs_v), 32'(exp_v));
    checkOutput("held_result", 32'(res8), 32'd3);

    $display("[TB] stray start pulses");
    applyStimulus(8, 16'd20, 16'd30, 1'b0, 3);
    applyStimulus(8, 16'd200, 16'd90, 1'b1, 8);

    $display("[TB] reset mid-operation");
    a_bus = 16'd7; b_bus = 16'd3; sub_bus = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    checkOutput("rst_abort", {busy8, done8, ser8, cout8, ovf8, res8}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hold", {busy8, done8}, 32'd0);
    @(negedge clk) clr_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_no_done", {busy8, done8}, 32'd0);
    applyStimulus(8, 16'd6, 16'd4, 1'b0, 0);

    $display("[TB] random 8-bit operations");
    for (int k = 0; k < 20; k++)
      applyStimulus(8, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'($urandom), 0);

    $display("[TB] 16-bit instance");
    applyStimulus(16, 16'hFFFF, 16'h0001, 1'b0, 0);
    applyStimulus(16, 16'h8000, 16'h0001, 1'b1, 0);
    for (int k = 0; k < 6; k++)
      applyStimulus(16, 16'($urandom), 16'($urandom), 1'($urandom), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
